// File: rtl/fpu_opnd_unpack.sv
// Operand unpack ahead of the FPU exponent path: gathers 1-2 operands of 1-2 words,
// extracts sign/biased exponent, classifies, and holds results while cyc0_rdy is high.
module fpu_opnd_unpack (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        fpuhold,
  input  logic        op_valid,
  input  logic [31:0] op_data,
  input  logic        op_dprec,
  input  logic        op_two,
  output logic        op_ready,
  input  logic        op_start,
  output logic        cyc0_rdy,
  output logic [10:0] aexpin,
  output logic [10:0] bexpin,
  output logic        asign,
  output logic        bsign,
  output logic        azero,
  output logic        adnrm,
  output logic        ainf,
  output logic        anan,
  output logic        bzero,
  output logic        bdnrm,
  output logic        binf,
  output logic        bnan,
  output logic        dprec
);

  typedef enum logic [2:0] {A_HI, A_LO, B_HI, B_LO, RDY} state_t;

  state_t      state_q, state_d;
  logic        dp_lat_q, two_lat_q;
  logic [10:0] exp_hi_q;
  logic        sign_hi_q, fnz_hi_q;
  logic [10:0] aexp_q, bexp_q;
  logic        asign_q, bsign_q, dprec_q;
  logic [3:0]  aflg_q, bflg_q;  // {zero, dnrm, inf, nan}

  logic        accept, is_hi, cur_dp, cur_two;
  logic [10:0] hi_exp, cmp_exp;
  logic        hi_fnz, hi_e0, hi_e1, cmp_fnz, cmp_e0, cmp_e1, cmp_sign;
  logic        done_a, done_b;
  logic [3:0]  cmp_flg;

  assign op_ready = ~fpuhold & (state_q != RDY);
  assign accept   = op_valid & op_ready;
  assign is_hi    = (state_q == A_HI) | (state_q == B_HI);
  // Precision/count are live on the A_HI accept, latched afterwards.
  assign cur_dp   = (state_q == A_HI) ? op_dprec : dp_lat_q;
  assign cur_two  = (state_q == A_HI) ? op_two   : two_lat_q;

  assign hi_exp = cur_dp ? op_data[30:20] : {op_data[30:23], 3'b000};
  assign hi_fnz = cur_dp ? |op_data[19:0] : |op_data[22:0];
  assign hi_e0  = cur_dp ? ~|op_data[30:20] : ~|op_data[30:23];
  assign hi_e1  = cur_dp ? &op_data[30:20]  : &op_data[30:23];

  // Low words only occur for doubles, so the held exponent is the full 11-bit field.
  assign cmp_exp  = is_hi ? hi_exp      : exp_hi_q;
  assign cmp_sign = is_hi ? op_data[31] : sign_hi_q;
  assign cmp_fnz  = is_hi ? hi_fnz      : (fnz_hi_q | (|op_data));
  assign cmp_e0   = is_hi ? hi_e0       : ~|exp_hi_q;
  assign cmp_e1   = is_hi ? hi_e1       : &exp_hi_q;
  assign cmp_flg  = {cmp_e0 & ~cmp_fnz, cmp_e0 & cmp_fnz, cmp_e1 & ~cmp_fnz, cmp_e1 & cmp_fnz};

  assign done_a = accept & (((state_q == A_HI) & ~cur_dp) | (state_q == A_LO));
  assign done_b = accept & (((state_q == B_HI) & ~cur_dp) | (state_q == B_LO));

  always_comb begin
    state_d = state_q;
    case (state_q)
      A_HI: if (accept) state_d = op_dprec ? A_LO : (op_two ? B_HI : RDY);
      A_LO: if (accept) state_d = two_lat_q ? B_HI : RDY;
      B_HI: if (accept) state_d = dp_lat_q ? B_LO : RDY;
      B_LO: if (accept) state_d = RDY;
      RDY:  if (op_start & ~fpuhold) state_d = A_HI;
      default: state_d = A_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q   <= A_HI;
      dp_lat_q  <= 1'b0;
      two_lat_q <= 1'b0;
      exp_hi_q  <= '0;
      sign_hi_q <= 1'b0;
      fnz_hi_q  <= 1'b0;
      aexp_q    <= '0;
      bexp_q    <= '0;
      asign_q   <= 1'b0;
      bsign_q   <= 1'b0;
      aflg_q    <= '0;
      bflg_q    <= '0;
      dprec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == A_HI) begin
        dp_lat_q  <= op_dprec;
        two_lat_q <= op_two;
      end
      if (accept && is_hi) begin
        exp_hi_q  <= hi_exp;
        sign_hi_q <= op_data[31];
        fnz_hi_q  <= hi_fnz;
      end
      if (done_a) begin
        aexp_q  <= cmp_exp;
        asign_q <= cmp_sign;
        aflg_q  <= cmp_flg;
        dprec_q <= cur_dp;
        if (!cur_two) begin
          bexp_q  <= '0;
          bsign_q <= 1'b0;
          bflg_q  <= '0;
        end
      end
      if (done_b) begin
        bexp_q  <= cmp_exp;
        bsign_q <= cmp_sign;
        bflg_q  <= cmp_flg;
      end
    end
  end

  assign cyc0_rdy = (state_q == RDY);
  assign aexpin   = aexp_q;
  assign bexpin   = bexp_q;
  assign asign    = asign_q;
  assign bsign    = bsign_q;
  assign {azero, adnrm, ainf, anan} = aflg_q;
  assign {bzero, bdnrm, binf, bnan} = bflg_q;
  assign dprec    = dprec_q;

endmodule

// File: tb/tb_fpu_opnd_unpack.sv
// Randomized bench for fpu_opnd_unpack against an IEEE-field reference model.
module tb_fpu_opnd_unpack;

  logic        clk = 1'b0;
  logic        reset_l, fpuhold, op_valid, op_dprec, op_two, op_start;
  logic [31:0] op_data;
  logic        op_ready, cyc0_rdy, asign, bsign, dprec;
  logic [10:0] aexpin, bexpin;
  logic        azero, adnrm, ainf, anan, bzero, bdnrm, binf, bnan;

  int n_checks = 0;
  int n_errors = 0;

  // Expected operand: [15] sign, [14:4] biased exponent, [3:0] {zero,dnrm,inf,nan}
  logic [15:0] ea, eb;
  logic        edp;

  always #5 clk = ~clk;

  fpu_opnd_unpack dut (
    .clk(clk), .reset_l(reset_l), .fpuhold(fpuhold), .op_valid(op_valid),
    .op_data(op_data), .op_dprec(op_dprec), .op_two(op_two), .op_ready(op_ready),
    .op_start(op_start), .cyc0_rdy(cyc0_rdy), .aexpin(aexpin), .bexpin(bexpin),
    .asign(asign), .bsign(bsign), .azero(azero), .adnrm(adnrm), .ainf(ainf),
    .anan(anan), .bzero(bzero), .bdnrm(bdnrm), .binf(binf), .bnan(bnan),
    .dprec(dprec)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Classify from the full IEEE value: fields are taken from the assembled number.
  function automatic logic [15:0] ref_op(input bit dp, input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] v;
    longint unsigned frac;
    int e, emax, expo;
    logic z, d, i, n;
    if (dp) begin
      v = {hi, lo};
      e = int'(v[62:52]);
      frac = longint'(v[51:0]);
      emax = 2047;
      expo = e;
    end else begin
      e = int'(hi[30:23]);
      frac = longint'(hi[22:0]);
      emax = 255;
      expo = e * 8;
    end
    z = (e == 0) && (frac == 0);
    d = (e == 0) && (frac != 0);
    i = (e == emax) && (frac == 0);
    n = (e == emax) && (frac != 0);
    return {hi[31], 11'(expo), z, d, i, n};
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, "_aexp"},  32'(aexpin), 32'(ea[14:4]));
    chk({tag, "_asign"}, 32'(asign),  32'(ea[15]));
    chk({tag, "_aflg"},  32'({azero, adnrm, ainf, anan}), 32'(ea[3:0]));
    chk({tag, "_bexp"},  32'(bexpin), 32'(eb[14:4]));
    chk({tag, "_bsign"}, 32'(bsign),  32'(eb[15]));
    chk({tag, "_bflg"},  32'({bzero, bdnrm, binf, bnan}), 32'(eb[3:0]));
    chk({tag, "_dprec"}, 32'(dprec),  32'(edp));
  endtask

  task automatic chk_reset_state(input string tag);
    ea = '0; eb = '0; edp = 1'b0;
    check_outs(tag);
    chk({tag, "_cyc0"}, 32'(cyc0_rdy), 32'd0);
    chk({tag, "_rdy"},  32'(op_ready), 32'd1);
  endtask

  // Entry and exit at a negedge; returns on the negedge after the word's accept.
  task automatic put_word(input logic [31:0] w, input bit d, input bit t,
                          input int forced_hold, input bit rnd_hold);
    int n;
    int gap;
    gap = rnd_hold ? $urandom_range(0, 2) : 0;
    for (int g = 0; g < gap; g++) begin
      op_valid = 1'b0; op_data = $urandom; op_dprec = 1'($urandom); op_two = 1'($urandom);
      fpuhold = 1'($urandom);
      @(negedge clk);
    end
    op_valid = 1'b1; op_data = w; op_dprec = d; op_two = t;
    for (int h = 0; h < forced_hold; h++) begin
      fpuhold = 1'b1;
      #1 chk("hold_rdy", 32'(op_ready), 32'd0);
      @(negedge clk);
      chk("hold_cyc0", 32'(cyc0_rdy), 32'd0);
    end
    n = 0;
    forever begin
      fpuhold = rnd_hold ? ($urandom_range(0, 3) == 0) : 1'b0;
      #1;
      if (op_ready) break;
      n++;
      if (n > 30) begin
        chk("accept_timeout", 32'(op_ready), 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    op_valid = 1'b0; fpuhold = 1'b0; op_data = $urandom;
    op_dprec = 1'($urandom); op_two = 1'($urandom);
  endtask

  task automatic run_txn(input bit dp, input bit two,
                         input logic [31:0] ahi, input logic [31:0] alo,
                         input logic [31:0] bhi, input logic [31:0] blo,
                         input int hold_at, input bit rnd_hold);
    logic [31:0] seq[4];
    int nw;
    ea  = ref_op(dp, ahi, alo);
    eb  = two ? ref_op(dp, bhi, blo) : 16'h0;
    edp = dp;
    nw = 0;
    seq[nw++] = ahi;
    if (dp) seq[nw++] = alo;
    if (two) begin
      seq[nw++] = bhi;
      if (dp) seq[nw++] = blo;
    end
    for (int i = 0; i < nw; i++) begin
      put_word(seq[i], (i == 0) ? dp : 1'($urandom), (i == 0) ? two : 1'($urandom),
               (i == hold_at) ? 3 : 0, rnd_hold);
      chk((i == nw - 1) ? "cyc0_last" : "cyc0_mid", 32'(cyc0_rdy), 32'(i == nw - 1));
    end
    check_outs("done");
  endtask

  // Linger in RDY, then consume with op_start (optionally while stalled).
  task automatic finish_txn(input int delay, input int hold_cyc);
    for (int k = 0; k < delay; k++) begin
      op_start = 1'b0;
      @(negedge clk);
      chk("rdy_cyc0", 32'(cyc0_rdy), 32'd1);
      chk("rdy_ready", 32'(op_ready), 32'd0);
      check_outs("rdy_hold");
    end
    for (int k = 0; k < hold_cyc; k++) begin
      op_start = 1'b1; fpuhold = 1'b1;
      @(negedge clk);
      chk("start_stall_cyc0", 32'(cyc0_rdy), 32'd1);
    end
    op_start = 1'b1; fpuhold = 1'b0;
    @(negedge clk);
    op_start = 1'b0;
    chk("start_cyc0", 32'(cyc0_rdy), 32'd0);
    chk("start_ready", 32'(op_ready), 32'd1);
  endtask

  function automatic logic [63:0] rnd_opnd(input bit dp);
    int kind;
    logic [10:0] e;
    logic [51:0] f;
    kind = $urandom_range(0, 3);
    e = 11'($urandom);
    if (!dp) e[10:8] = 3'b000;
    if (kind == 0) e = '0;
    if (kind == 1) e = dp ? 11'h7FF : 11'h0FF;
    f = {20'($urandom), 32'($urandom)};
    case ($urandom_range(0, 3))
      0: f = '0;
      1: f[51:32] = '0;
      2: f[31:0] = '0;
      default: ;
    endcase
    if (dp) return {1'($urandom), e, f};
    return {1'($urandom), e[7:0], f[22:0], 32'h0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b;
    bit dp, two;
    reset_l = 1'b0; fpuhold = 1'b0; op_valid = 1'b0; op_data = '0;
    op_dprec = 1'b0; op_two = 1'b0; op_start = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    reset_l = 1'b1;

    run_txn(1'b0, 1'b1, 32'h3F800000, 32'h0, 32'hC0000000, 32'h0, -1, 1'b0);
    chk("dir_aexp", 32'(aexpin), 32'h3F8);
    chk("dir_bexp", 32'(bexpin), 32'h400);
    chk("dir_bsign", 32'(bsign), 32'd1);
    finish_txn(0, 0);

    run_txn(1'b1, 1'b1, 32'h7FF00000, 32'h0, 32'h7FF00000, 32'h1, -1, 1'b0);
    chk("dir_ainf", 32'(ainf), 32'd1);
    chk("dir_bnan", 32'(bnan), 32'd1);
    finish_txn(1, 0);

    run_txn(1'b0, 1'b0, 32'h00000001, 32'h0, 32'h0, 32'h0, -1, 1'b0);
    chk("dir_adnrm", 32'(adnrm), 32'd1);
    finish_txn(5, 0);

    run_txn(1'b1, 1'b1, 32'hC0934000, 32'h12345678, 32'h80000000, 32'h0, 1, 1'b0);
    finish_txn(0, 3);

    run_txn(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, -1, 1'b0);
    chk("dir_azero", 32'(azero), 32'd1);
    finish_txn(0, 0);

    // Load nonzero results, then reset partway through the next operand.
    run_txn(1'b1, 1'b1, 32'hFFF00000, 32'h0, 32'h40000000, 32'h0, -1, 1'b0);
    finish_txn(0, 0);
    put_word(32'h40000000, 1'b1, 1'b1, 0, 1'b0);
    reset_l = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state("midreset");
    reset_l = 1'b1;
    run_txn(1'b0, 1'b0, 32'h7F800000, 32'h0, 32'h0, 32'h0, -1, 1'b0);
    finish_txn(0, 0);

    for (int t = 0; t < 150; t++) begin
      dp = 1'($urandom); two = 1'($urandom);
      a = rnd_opnd(dp); b = rnd_opnd(dp);
      run_txn(dp, two, a[63:32], a[31:0], b[63:32], b[31:0],
              ($urandom_range(0, 7) == 0) ? 1 : -1, 1'b1);
      finish_txn($urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
